pcs_tx: RTL
===========

# pcs_tx

100BASE-X PCS transmit stage: consumes the nibble-wide MII transmit interface driven by the half-duplex MAC TX, 4B/5B-encodes it per 802.3 Clause 24, and serialises one code bit per `clk` to the PMA. It substitutes J/K for the first preamble octet, appends T/R at end of stream, and emits H on transmit error. It also generates the MII `crs`/`col` that the MAC uses for deferral and collision detection, from its own transmit state and the receive PCS's `receiving` flag.

## Interface
- Parameters: none. The code group is fixed at 5 bits; `clk` is the 125 MHz bit clock and `mii_tx_ce` pulses once every 5 cycles.
- `clk`  in  1  bit clock, all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mii_tx_ce`  in  1  nibble strobe; MII inputs sampled only on cycles where it is 1.
- `mii_tx_en`  in  1  MII transmit enable.
- `mii_txd`  in  4  MII transmit nibble.
- `mii_tx_er`  in  1  MII transmit error (see Configuration).
- `link_status`  in  1  1 = link OK; 0 forces IDLE.
- `rx_receiving`  in  1  receive PCS is inside a stream.
- `pma_data`  out  1  serial code bit to the PMA.
- `mii_crs`  out  1  carrier sense to the MAC.
- `mii_col`  out  1  collision to the MAC.
- `transmitting`  out  1  PCS is inside a transmitted stream (J through R inclusive).

## Operation
- States: IDLE, START_J, START_K, DATA, END_T, END_R.
- Code group selection happens on each sampled nibble (`mii_tx_ce`=1). Selection depends on the current state and the sampled inputs:
  - IDLE, tx_en=1: send J (11000), go to START_K.
  - IDLE, tx_en=0: send I (11111).
  - START_K (the second preamble nibble): send K (10001) regardless of txd, go to DATA. If tx_en=0 here, send T instead and go to END_R.
  - DATA, tx_en=1: send the Table 24-1 data group for txd (0→11110, 5→01011, D→11011, F→11101). If tx_er=1, send H (00100) instead.
  - DATA, tx_en=0: send T (01101), go to END_R.
  - END_R: send R (00111). If tx_en=1, go to START_K (back-to-back stream, R replaces J); otherwise go to IDLE.
- `link_status`=0 forces state IDLE and I groups on every strobe. The current group still finishes shifting.
- Serialiser: a 5-bit shift register, loaded on the cycle after a strobe and shifted left each cycle. `pma_data` is bit 4, so the leftmost code bit goes first. Between loads it shifts in 1s.
- `transmitting` is 1 from the J load through the R load, inclusive.
- `mii_crs` = `transmitting` | `rx_receiving`.
- `mii_col` = `transmitting` & `rx_receiving`.

## Timing
- Reset values: state IDLE, shift register 11111, `pma_data`=1, `transmitting`=0, `mii_crs`=0, `mii_col`=0.
- Strobe sampled at edge N: bit 4 of the new group appears at edge N+1 and bit 0 at edge N+5. Latency is 1 clk.
- `transmitting` updates at edge N+1, same as the first bit. `mii_crs`/`mii_col` follow combinationally from registered `transmitting` and `rx_receiving`.
- Strobe spacing less than 5: the reload overwrites the unsent bits; no error is flagged. Spacing greater than 5: 1s are padded between groups.
- `rst_n` deasserted mid-group: the output goes immediately to 1 and the next strobe starts from IDLE. A nibble sampled while in reset is discarded.
- Simultaneous `link_status` fall and a strobe: IDLE wins and I is loaded.

## Configuration
- `PCS_TX_ERR_EN` defined: `mii_tx_er`=1 in DATA produces H. It has no effect in other states.
- Undefined: `mii_tx_er` is ignored (port retained and unconnected internally), so the data group is always sent.

## Test plan
- Reset, `link_status`=1, no tx_en, strobe every 5 cycles → `pma_data` constant 1, `transmitting`=0.
- Frame: 16 nibbles 5, one nibble D, then two data nibbles 0 and F, then tx_en=0 → serial stream is J K, then 14×01011, then 11011, 11110, 11101, T, R, then 1s. `transmitting` is high from the J first bit through the R last bit.
- Same frame with tx_er=1 on nibble 0, macro defined → 00100 replaces 11110. Macro undefined → 11110 is sent.
- `rx_receiving`=1 during the frame → `mii_col`=1 exactly while `transmitting`=1, and `mii_crs`=1 throughout.
- tx_en dropped after one nibble → J, T, R, I. tx_en reasserted at END_R → R, K, data.
- `rst_n` pulsed low mid-DATA, and separately `link_status`=0 mid-frame → output goes to 1s with no T/R, state IDLE, `transmitting`=0.

Source files
------------

// File: rtl/pcs_tx.sv
// 100BASE-X PCS transmit: 4B/5B encoding of the MII TX nibble stream, J/K/T/R/H framing, serialiser, crs/col.
// Optional feature: define PCS_TX_ERR_EN to replace data groups with H while mii_tx_er is high in DATA.
module pcs_tx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mii_tx_ce,
    input  logic       mii_tx_en,
    input  logic [3:0] mii_txd,
    input  logic       mii_tx_er,
    input  logic       link_status,
    input  logic       rx_receiving,
    output logic       pma_data,
    output logic       mii_crs,
    output logic       mii_col,
    output logic       transmitting,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START_J = 3'd1,
        ST_START_K = 3'd2,
        ST_DATA    = 3'd3,
        ST_END_T   = 3'd4,
        ST_END_R   = 3'd5
    } state_t;

    localparam logic [4:0] CG_I = 5'b11111;
    localparam logic [4:0] CG_J = 5'b11000;
    localparam logic [4:0] CG_K = 5'b10001;
    localparam logic [4:0] CG_T = 5'b01101;
    localparam logic [4:0] CG_R = 5'b00111;
    localparam logic [4:0] CG_H = 5'b00100;

    function automatic logic [4:0] enc_data(input logic [3:0] d);
        enc_data = CG_I;
        case (d)
            4'h0: enc_data = 5'b11110;
            4'h1: enc_data = 5'b01001;
            4'h2: enc_data = 5'b10100;
            4'h3: enc_data = 5'b10101;
            4'h4: enc_data = 5'b01010;
            4'h5: enc_data = 5'b01011;
            4'h6: enc_data = 5'b01110;
            4'h7: enc_data = 5'b01111;
            4'h8: enc_data = 5'b10010;
            4'h9: enc_data = 5'b10011;
            4'hA: enc_data = 5'b10110;
            4'hB: enc_data = 5'b10111;
            4'hC: enc_data = 5'b11010;
            4'hD: enc_data = 5'b11011;
            4'hE: enc_data = 5'b11100;
            4'hF: enc_data = 5'b11101;
        endcase
    endfunction

    state_t     state_q;
    state_t     state_nxt;
    logic [4:0] grp_nxt;
    logic       grp_tx_nxt;
    logic [4:0] grp_q;
    logic       grp_tx_q;
    logic       load_q;
    logic [4:0] shreg_q;
    logic       data_err;

`ifdef PCS_TX_ERR_EN
    assign data_err = mii_tx_er;
`else
    logic unused_tx_er;
    assign unused_tx_er = mii_tx_er;
    assign data_err     = 1'b0;
`endif

    // MII side is a strobe-qualified stream: mii_tx_ce is the valid, the PCS is always
    // ready, so every nibble present while mii_tx_ce=1 is consumed on that edge.
    always_comb begin
        state_nxt  = state_q;
        grp_nxt    = CG_I;
        grp_tx_nxt = 1'b0;
        if (!link_status) begin
            state_nxt = ST_IDLE;
        end else if (mii_tx_ce) begin
            case (state_q)
                ST_START_K: begin
                    grp_tx_nxt = 1'b1;
                    if (mii_tx_en) begin
                        grp_nxt   = CG_K;
                        state_nxt = ST_DATA;
                    end else begin
                        grp_nxt   = CG_T;
                        state_nxt = ST_END_R;
                    end
                end
                ST_DATA: begin
                    grp_tx_nxt = 1'b1;
                    if (mii_tx_en) begin
                        grp_nxt = data_err ? CG_H : enc_data(mii_txd);
                    end else begin
                        grp_nxt   = CG_T;
                        state_nxt = ST_END_R;
                    end
                end
                ST_END_R: begin
                    // R stands in for J when a new stream follows immediately
                    grp_nxt    = CG_R;
                    grp_tx_nxt = 1'b1;
                    state_nxt  = mii_tx_en ? ST_START_K : ST_IDLE;
                end
                default: begin
                    if (mii_tx_en) begin
                        grp_nxt    = CG_J;
                        grp_tx_nxt = 1'b1;
                        state_nxt  = ST_START_K;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Group is chosen on the strobe edge and loaded one edge later, so the serial
    // output and transmitting change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grp_q        <= CG_I;
            grp_tx_q     <= 1'b0;
            load_q       <= 1'b0;
            shreg_q      <= CG_I;
            transmitting <= 1'b0;
        end else begin
            state_q <= state_nxt;
            load_q  <= mii_tx_ce;
            if (mii_tx_ce) begin
                grp_q    <= grp_nxt;
                grp_tx_q <= grp_tx_nxt;
            end
            if (load_q) begin
                shreg_q      <= grp_q;
                transmitting <= grp_tx_q;
            end else begin
                shreg_q <= {shreg_q[3:0], 1'b1};
            end
        end
    end

    assign pma_data  = shreg_q[4];
    assign mii_crs   = transmitting | rx_receiving;
    assign mii_col   = transmitting & rx_receiving;
    assign state_dbg = state_q;

endmodule
